// File: rtl/hilo_unit.sv
// ============================================================================
// Module      : hilo_unit
// Description : HI/LO register stage. Captures mult products, executes
//               mthi/mtlo, and (with HILO_DIV_EN defined) runs div/divu on a
//               32-step restoring divider that stalls the pipe via busy.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             idle;
  logic             accept;
  logic             res_wr;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept = op_valid && idle;

`ifdef HILO_DIV_EN
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam int         CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             is_div;
  logic             is_signed;
  logic             unused_rem_msb;

  // Dividend lives in quot_q and is shifted out MSB-first into the remainder.
  assign rem_sh    = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvsr_q};
  assign is_div    = accept && ((op == OP_DIV) || (op == OP_DIVU));
  assign is_signed = (op == OP_DIV);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          if (b == '0) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            dvsr_d  = (is_signed && b[WIDTH-1]) ? -b : b;
            quot_d  = (is_signed && a[WIDTH-1]) ? -a : a;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = is_signed && a[WIDTH-1];
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        quot_d = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d  = trial[WIDTH] ? rem_sh : trial;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // The remainder never reaches bit WIDTH after a completed step.
  assign unused_rem_msb = rem_q[WIDTH];

  assign idle        = (state_q == S_IDLE);
  assign res_wr      = (state_q == S_FIX);
  assign res_hi      = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign res_lo      = qneg_q ? -quot_q : quot_q;
  assign busy        = !idle;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
`else
  logic unused_b;

  assign unused_b    = ^b;
  assign idle        = 1'b1;
  assign res_wr      = 1'b0;
  assign res_hi      = '0;
  assign res_lo      = '0;
  assign busy        = 1'b0;
  assign done        = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (res_wr) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (accept) begin
      case (op)
        OP_MULT: begin
          hi_d = alu_hi;
          lo_d = alu_lo;
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire
